// File: rtl/psr_flag_ctrl_pkg.sv
// Shared definitions for the 65C02 status-register block: flag bit positions,
// flag-instruction encodings, interrupt-entry FSM states and P packing helpers.
package psr_pkg;

  localparam int PSR_N = 7;
  localparam int PSR_V = 6;
  localparam int PSR_5 = 5;
  localparam int PSR_B = 4;
  localparam int PSR_D = 3;
  localparam int PSR_I = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_C = 0;

  localparam logic [7:0] PSR_RESET_P = 8'h34;

  typedef enum logic [2:0] {
    FOP_CLC = 3'd0,
    FOP_SEC = 3'd1,
    FOP_CLI = 3'd2,
    FOP_SEI = 3'd3,
    FOP_CLD = 3'd4,
    FOP_SED = 3'd5,
    FOP_CLV = 3'd6
  } flag_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    PUSH = 2'd2,
    MASK = 2'd3
  } psr_fsm_e;

  // Only N,V,D,I,Z,C are storage; bits 5 and 4 are not kept in the register.
  function automatic logic [5:0] psr_pack(input logic [7:0] p);
    return {p[PSR_N], p[PSR_V], p[PSR_D], p[PSR_I], p[PSR_Z], p[PSR_C]};
  endfunction

  function automatic logic [7:0] psr_unpack(input logic [5:0] r);
    return {r[5], r[4], 1'b1, 1'b1, r[3], r[2], r[1], r[0]};
  endfunction

endpackage

// File: rtl/psr_flag_ctrl_if.sv
// Stack-push handshake carrying the P snapshot during interrupt entry.
interface psr_flag_ctrl_if;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;

  modport master (output push_valid, output push_data, input push_ready);
  modport slave  (input push_valid, input push_data, output push_ready);
endinterface

// File: rtl/psr_flag_ctrl_so_edge_sync.sv
// Synchroniser for the asynchronous SO pin plus a one-cycle falling-edge pulse.
module so_edge_sync #(
  parameter int SO_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic so_n_i,
  output logic fall_o
);

  logic [SO_SYNC_STAGES-1:0] sync_q;
  logic                      prev_q;
  logic [SO_SYNC_STAGES:0]   arm_q;

  // arm_q fills with ones once the chain and prev_q hold only post-reset samples,
  // so a pin already low when reset releases is not mistaken for an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SO_SYNC_STAGES-2:0], so_n_i};
      prev_q <= sync_q[SO_SYNC_STAGES-1];
      arm_q  <= {arm_q[SO_SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign fall_o = (&arm_q) & prev_q & ~sync_q[SO_SYNC_STAGES-1];

endmodule

// File: rtl/psr_flag_ctrl.sv
// 65C02 processor status register: per-flag write arbitration, SO pin handling
// and the interrupt-entry sequence that pushes P and then masks interrupts.
module psr_flag_ctrl
  import psr_pkg::*;
#(
  parameter int         SO_SYNC_STAGES = 2,
  parameter logic [7:0] RESET_P        = PSR_RESET_P,
  parameter bit         CLEAR_D_ON_INT = 1'b1
) (
  input  logic              phi2,
  input  logic              resb,
  input  logic [3:0]        alu_nvzc,
  input  logic [3:0]        alu_we,
  input  logic              flag_op_v,
  input  logic [2:0]        flag_op,
  input  logic              pull_load,
  input  logic [7:0]        db_in,
  input  logic              int_start,
  input  logic              int_is_brk,
  input  logic              so_n,
  output logic [7:0]        p_out,
  output logic              int_done,
  output logic              busy,
  psr_flag_ctrl_if.master   push
);

  psr_fsm_e   state_q, state_d;
  logic [5:0] p_q, p_d;
  logic       brk_q, brk_d;
  logic [7:0] push_data_q, push_data_d;
  logic       push_valid_c;
  logic [7:0] push_data_c;
  logic       mask_en;
  logic       so_fall;
  logic [7:0] p_cur;
  logic [7:0] p_nxt;
  logic [7:0] snap;

  so_edge_sync #(
    .SO_SYNC_STAGES (SO_SYNC_STAGES)
  ) u_so_sync (
    .clk_i  (phi2),
    .rst_ni (resb),
    .so_n_i (so_n),
    .fall_o (so_fall)
  );

  assign p_cur = psr_unpack(p_q);
  assign snap  = {p_q[5], p_q[4], 1'b1, brk_q, p_q[3:0]};

  // Interrupt-entry sequencer
  always_comb begin
    state_d      = state_q;
    brk_d        = brk_q;
    push_data_d  = push_data_q;
    push_valid_c = 1'b0;
    push_data_c  = push_data_q;
    mask_en      = 1'b0;
    int_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (int_start) begin
          state_d = SNAP;
          brk_d   = int_is_brk;
        end
      end
      SNAP: begin
        push_valid_c = 1'b1;
        push_data_c  = snap;
        push_data_d  = snap;
        state_d      = push.push_ready ? MASK : PUSH;
      end
      PUSH: begin
        push_valid_c = 1'b1;
        if (push.push_ready) state_d = MASK;
      end
      MASK: begin
        mask_en  = 1'b1;
        int_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag arbitration: lowest priority source applied first, later ones override.
  always_comb begin
    p_nxt = p_cur;
    if (so_fall) p_nxt[PSR_V] = 1'b1;
    if (alu_we[3]) p_nxt[PSR_N] = alu_nvzc[3];
    if (alu_we[2]) p_nxt[PSR_V] = alu_nvzc[2];
    if (alu_we[1]) p_nxt[PSR_Z] = alu_nvzc[1];
    if (alu_we[0]) p_nxt[PSR_C] = alu_nvzc[0];
    if (flag_op_v) begin
      case (flag_op)
        FOP_CLC: p_nxt[PSR_C] = 1'b0;
        FOP_SEC: p_nxt[PSR_C] = 1'b1;
        FOP_CLI: p_nxt[PSR_I] = 1'b0;
        FOP_SEI: p_nxt[PSR_I] = 1'b1;
        FOP_CLD: p_nxt[PSR_D] = 1'b0;
        FOP_SED: p_nxt[PSR_D] = 1'b1;
        FOP_CLV: p_nxt[PSR_V] = 1'b0;
        default: ;
      endcase
    end
    if (pull_load) p_nxt = db_in;
    if (mask_en) begin
      p_nxt[PSR_I] = 1'b1;
      if (CLEAR_D_ON_INT) p_nxt[PSR_D] = 1'b0;
    end
    p_d = psr_pack(p_nxt);
  end

  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      state_q     <= IDLE;
      p_q         <= psr_pack(RESET_P);
      brk_q       <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      brk_q       <= brk_d;
      push_data_q <= push_data_d;
    end
  end

  assign p_out           = p_cur;
  assign busy            = (state_q != IDLE);
  assign push.push_valid = push_valid_c;
  assign push.push_data  = push_data_c;

  // A new interrupt request may only arrive once the previous entry has finished.
  assert property (@(posedge phi2) disable iff (!resb) !(int_start && busy));

endmodule

// File: tb/tb_psr_flag_ctrl.sv
// Directed bench for psr_flag_ctrl: two instances, one clearing D on interrupt
// entry and one leaving D alone, driven from the same stimulus.
module tb_psr_flag_ctrl;
  import psr_pkg::*;

  logic       phi2 = 1'b0;
  logic       resb = 1'b1;
  logic [3:0] alu_nvzc = '0;
  logic [3:0] alu_we = '0;
  logic       flag_op_v = 1'b0;
  logic [2:0] flag_op = '0;
  logic       pull_load = 1'b0;
  logic [7:0] db_in = '0;
  logic       int_start = 1'b0;
  logic       int_is_brk = 1'b0;
  logic       push_ready = 1'b0;
  logic       so_n = 1'b1;

  logic [7:0] p_out0, p_out1;
  logic       int_done0, int_done1, busy0, busy1;

  int n_run = 0;
  int n_fail = 0;

  psr_flag_ctrl_if ifc0 ();
  psr_flag_ctrl_if ifc1 ();
  assign ifc0.push_ready = push_ready;
  assign ifc1.push_ready = push_ready;

  psr_flag_ctrl #(.SO_SYNC_STAGES(2), .RESET_P(8'h34), .CLEAR_D_ON_INT(1'b1)) dut (
    .phi2(phi2), .resb(resb), .alu_nvzc(alu_nvzc), .alu_we(alu_we),
    .flag_op_v(flag_op_v), .flag_op(flag_op), .pull_load(pull_load), .db_in(db_in),
    .int_start(int_start), .int_is_brk(int_is_brk), .so_n(so_n),
    .p_out(p_out0), .int_done(int_done0), .busy(busy0), .push(ifc0)
  );

  psr_flag_ctrl #(.SO_SYNC_STAGES(2), .RESET_P(8'h34), .CLEAR_D_ON_INT(1'b0)) dut_nd (
    .phi2(phi2), .resb(resb), .alu_nvzc(alu_nvzc), .alu_we(alu_we),
    .flag_op_v(flag_op_v), .flag_op(flag_op), .pull_load(pull_load), .db_in(db_in),
    .int_start(int_start), .int_is_brk(int_is_brk), .so_n(so_n),
    .p_out(p_out1), .int_done(int_done1), .busy(busy1), .push(ifc1)
  );

  always #5 phi2 = ~phi2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic load_p(input logic [7:0] v);
    pull_load = 1'b1;
    db_in     = v;
    step();
    pull_load = 1'b0;
    db_in     = '0;
  endtask

  task automatic flag(input logic [2:0] op);
    flag_op_v = 1'b1;
    flag_op   = op;
    step();
    flag_op_v = 1'b0;
    flag_op   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset mid-cycle from an unknown state
    #3 resb = 1'b0;
    #1;
    chk("rst_p",     p_out0, 8'h34);
    chk("rst_busy",  {7'd0, busy0}, 8'h00);
    chk("rst_pv",    {7'd0, ifc0.push_valid}, 8'h00);
    chk("rst_done",  {7'd0, int_done0}, 8'h00);
    step(); step();
    resb = 1'b1;
    repeat (4) step();
    chk("rst_hold",  p_out0, 8'h34);

    // ALU writes only the enabled flags
    alu_nvzc = 4'b1011; alu_we = 4'b1001;
    step();
    alu_nvzc = '0; alu_we = '0;
    chk("alu_mask",  p_out0, 8'hB5);

    // Pull beats flag op and ALU in the same cycle
    pull_load = 1'b1; db_in = 8'h00; flag_op_v = 1'b1; flag_op = FOP_SEC;
    alu_we = 4'hF; alu_nvzc = 4'hF;
    step();
    pull_load = 1'b0; flag_op_v = 1'b0; alu_we = '0; alu_nvzc = '0;
    chk("conflict",  p_out0, 8'h30);

    alu_nvzc = 4'hF;
    step();
    alu_nvzc = '0;
    chk("alu_we0",   p_out0, 8'h30);
    flag(FOP_SEC); chk("sec",  p_out0, 8'h31);
    flag(FOP_SED); chk("sed",  p_out0, 8'h39);
    flag(3'd7);    chk("undef_op", p_out0, 8'h39);
    flag(FOP_CLD); chk("cld",  p_out0, 8'h31);
    flag(FOP_CLC); chk("clc",  p_out0, 8'h30);

    // BRK entry with a stalled push port
    load_p(8'h38);
    chk("brk_pre",   p_out0, 8'h38);
    int_start = 1'b1; int_is_brk = 1'b1; push_ready = 1'b0;
    step();
    int_start = 1'b0; int_is_brk = 1'b0;
    chk("brk_busy",  {7'd0, busy0}, 8'h01);
    chk("brk_pv1",   {7'd0, ifc0.push_valid}, 8'h01);
    chk("brk_pd1",   ifc0.push_data, 8'h38);
    step();
    chk("brk_pd2",   ifc0.push_data, 8'h38);
    step();
    chk("brk_pd3",   ifc0.push_data, 8'h38);
    chk("brk_nd_early", {7'd0, int_done0}, 8'h00);
    push_ready = 1'b1;
    step();
    push_ready = 1'b0;
    chk("brk_done",  {7'd0, int_done0}, 8'h01);
    chk("brk_pv_off", {7'd0, ifc0.push_valid}, 8'h00);
    step();
    chk("brk_done_1cyc", {7'd0, int_done0}, 8'h00);
    chk("brk_idle",  {7'd0, busy0}, 8'h00);
    chk("brk_final", p_out0, 8'h34);
    chk("brk_final_nd", p_out1, 8'h3C);

    // IRQ entry with the push port always ready
    load_p(8'hC3);
    chk("irq_pre",   p_out0, 8'hF3);
    push_ready = 1'b1;
    int_start = 1'b1; int_is_brk = 1'b0;
    step();
    int_start = 1'b0;
    chk("irq_pv",    {7'd0, ifc0.push_valid}, 8'h01);
    chk("irq_pd",    ifc0.push_data, 8'hE3);
    step();
    chk("irq_done",  {7'd0, int_done0}, 8'h01);
    chk("irq_i_late", p_out0, 8'hF3);
    step();
    push_ready = 1'b0;
    chk("irq_final", p_out0, 8'hF7);
    chk("irq_final_nd", p_out1, 8'hF7);

    // Flag write during PUSH changes P but not the pushed snapshot
    load_p(8'h00);
    int_start = 1'b1;
    step();
    int_start = 1'b0;
    chk("pw_snap",   ifc0.push_data, 8'h20);
    step();
    alu_we = 4'b0001; alu_nvzc = 4'b0001;
    step();
    alu_we = '0; alu_nvzc = '0;
    chk("pw_pd",     ifc0.push_data, 8'h20);
    chk("pw_p",      p_out0, 8'h31);
    push_ready = 1'b1;
    step(); step();
    push_ready = 1'b0;
    chk("pw_final",  p_out0, 8'h35);

    // SO falling edge sets V after the synchroniser delay
    load_p(8'h00);
    so_n = 1'b0;
    step(); chk("so_t1", p_out0, 8'h30);
    step(); chk("so_t2", p_out0, 8'h30);
    step(); chk("so_t3", p_out0, 8'h70);
    so_n = 1'b1;
    repeat (4) step();
    chk("so_rise",   p_out0, 8'h70);
    so_n = 1'b0;
    step(); step();
    flag(FOP_CLV);
    chk("so_clv",    p_out0, 8'h30);
    step();
    chk("so_clv_hold", p_out0, 8'h30);

    // Reset with SO held low must not produce a V set
    #2 resb = 1'b0;
    step(); step();
    resb = 1'b1;
    repeat (6) step();
    chk("so_rst_low", p_out0, 8'h34);
    so_n = 1'b1;
    repeat (4) step();

    // Reset during PUSH aborts the sequence
    int_start = 1'b1; int_is_brk = 1'b1; push_ready = 1'b0;
    step();
    int_start = 1'b0; int_is_brk = 1'b0;
    step();
    chk("ab_pv_pre", {7'd0, ifc0.push_valid}, 8'h01);
    #2 resb = 1'b0;
    #1;
    chk("ab_pv",     {7'd0, ifc0.push_valid}, 8'h00);
    chk("ab_busy",   {7'd0, busy0}, 8'h00);
    step();
    resb = 1'b1;
    push_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_no_done", {7'd0, int_done0}, 8'h00);
    end
    chk("ab_final",  p_out0, 8'h34);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
